uart_8250_rx: RTL and testbench

Receive path for the 8250-compatible UART: deserialises the asynchronous serial input using 16x oversampling, checks parity, stop bit and break, and queues each character with its error flags in a receive FIFO. It sits beside the transmit path inside the UART. The register front end pops characters through RHR reads and builds LSR bits 0–4 from this block's status outputs.

---
 rtl/uart_8250_rx.sv | 210 +++++++++++++++++++++
 tb/tb_uart_8250_rx.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_8250_rx.sv
// 8250-compatible UART receive path: 16x oversampled deserialiser with
// parity/framing/break detection feeding a receive FIFO with sticky overrun.
module uart_8250_rx #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic                         CLK_I,
    input  logic                         RST_I,
    input  logic                         RX_I,
    input  logic [15:0]                  DIVISOR_I,
    input  logic [1:0]                   WLS_I,
    input  logic                         PEN_I,
    input  logic                         EPS_I,
    input  logic                         RD_I,
    input  logic                         LSR_RD_I,
    input  logic                         FIFO_CLR_I,
    output logic [7:0]                   DATA_O,
    output logic                         DR_O,
    output logic                         OE_O,
    output logic                         PE_O,
    output logic                         FE_O,
    output logic                         BI_O,
    output logic [$clog2(FIFO_DEPTH):0]  COUNT_O
);

    // state  | meaning
    // IDLE   | waiting for a falling edge on the synchronised line
    // START  | mid-start-bit validation at tick_cnt 7
    // DATA   | sampling data bits LSB first at tick_cnt 15
    // PARITY | sampling the parity bit
    // STOP   | sampling the stop bit, then pushing the character
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    state_t       state;
    logic         rx_meta, rx_s, rx_prev;
    logic [15:0]  presc;
    logic [15:0]  div_m1;
    logic         tick;
    logic         start_det;
    logic [3:0]   tick_cnt;
    logic [2:0]   bit_cnt;
    logic [7:0]   shift;
    logic [1:0]   wls_q;
    logic         pen_q, eps_q;
    logic         par_bit, pe_q;
    logic         push_vld;
    logic [10:0]  push_entry;

    logic [10:0]  mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
    logic [CW-1:0] count;
    logic [10:0]  head_q;
    logic         full, do_pop, do_push, overrun;

    assign div_m1    = (DIVISOR_I == 16'd0) ? 16'd0 : DIVISOR_I - 16'd1;
    assign tick      = (presc >= div_m1);
    assign start_det = (state == IDLE) && rx_prev && !rx_s;

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
            presc   <= 16'd0;
        end else begin
            rx_meta <= RX_I;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
            if (start_det || tick)
                presc <= 16'd0;
            else
                presc <= presc + 16'd1;
        end
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state      <= IDLE;
            tick_cnt   <= 4'd0;
            bit_cnt    <= 3'd0;
            shift      <= 8'd0;
            wls_q      <= 2'd0;
            pen_q      <= 1'b0;
            eps_q      <= 1'b0;
            par_bit    <= 1'b0;
            pe_q       <= 1'b0;
            push_vld   <= 1'b0;
            push_entry <= 11'd0;
        end else begin
            push_vld <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_det) begin
                        state    <= START;
                        tick_cnt <= 4'd0;
                        bit_cnt  <= 3'd0;
                        shift    <= 8'd0;
                        par_bit  <= 1'b0;
                        pe_q     <= 1'b0;
                        wls_q    <= WLS_I;
                        pen_q    <= PEN_I;
                        eps_q    <= EPS_I;
                    end
                end
                START: begin
                    if (tick) begin
                        if (tick_cnt == 4'd7) begin
                            tick_cnt <= 4'd0;
                            state    <= rx_s ? IDLE : DATA;
                        end else begin
                            tick_cnt <= tick_cnt + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        tick_cnt <= tick_cnt + 4'd1;
                        if (tick_cnt == 4'd15) begin
                            shift[bit_cnt] <= rx_s;
                            bit_cnt        <= bit_cnt + 3'd1;
                            if (bit_cnt == ({1'b0, wls_q} + 3'd4))
                                state <= pen_q ? PARITY : STOP;
                        end
                    end
                end
                PARITY: begin
                    if (tick) begin
                        tick_cnt <= tick_cnt + 4'd1;
                        if (tick_cnt == 4'd15) begin
                            par_bit <= rx_s;
                            pe_q    <= eps_q ? (rx_s != ^shift) : (rx_s != ~^shift);
                            state   <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        tick_cnt <= tick_cnt + 4'd1;
                        if (tick_cnt == 4'd15) begin
                            push_vld   <= 1'b1;
                            // break: all-zero data, parity (if any) and stop bit
                            push_entry <= {(shift == 8'd0) && !(pen_q && par_bit) && !rx_s,
                                           !rx_s, pe_q, shift};
                            state      <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign full       = (count == CW'(FIFO_DEPTH));
    assign do_pop     = RD_I && (count != '0) && !FIFO_CLR_I;
    assign do_push    = push_vld && !FIFO_CLR_I && (!full || do_pop);
    assign overrun    = push_vld && !FIFO_CLR_I && full && !do_pop;
    assign rd_ptr_nxt = rd_ptr + 1'b1;

    always_ff @(posedge CLK_I) begin
        if (do_push)
            mem[wr_ptr] <= push_entry;
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head_q <= 11'd0;
            OE_O   <= 1'b0;
        end else begin
            if (overrun)
                OE_O <= 1'b1;
            else if (LSR_RD_I)
                OE_O <= 1'b0;

            if (FIFO_CLR_I) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
                head_q <= 11'd0;
            end else begin
                if (do_push)
                    wr_ptr <= wr_ptr + 1'b1;
                if (do_pop)
                    rd_ptr <= rd_ptr_nxt;
                count <= count + CW'(do_push) - CW'(do_pop);
                // head tracks the entry at rd_ptr, bypassing the write when it lands there
                if (do_pop) begin
                    if (count == CW'(1))
                        head_q <= do_push ? push_entry : 11'd0;
                    else
                        head_q <= mem[rd_ptr_nxt];
                end else if (do_push && (count == '0)) begin
                    head_q <= push_entry;
                end
            end
        end
    end

    assign DATA_O  = head_q[7:0];
    assign PE_O    = head_q[8];
    assign FE_O    = head_q[9];
    assign BI_O    = head_q[10];
    assign DR_O    = (count != '0);
    assign COUNT_O = count;

endmodule

// File: tb/tb_uart_8250_rx.sv
// Directed bench for uart_8250_rx: vector table of framed characters plus
// hand-written sequences for latency, break, glitch, overrun, clear and reset.
module tb_uart_8250_rx;

    logic        CLK_I = 1'b0;
    logic        RST_I = 1'b1;
    logic        RX_I = 1'b1;
    logic [15:0] DIVISOR_I = 16'd1;
    logic [1:0]  WLS_I = 2'd3;
    logic        PEN_I = 1'b0;
    logic        EPS_I = 1'b0;
    logic        RD_I = 1'b0;
    logic        LSR_RD_I = 1'b0;
    logic        FIFO_CLR_I = 1'b0;
    logic [7:0]  DATA_O;
    logic        DR_O, OE_O, PE_O, FE_O, BI_O;
    logic [4:0]  COUNT_O;

    uart_8250_rx #(.FIFO_DEPTH(16)) dut (
        .CLK_I(CLK_I), .RST_I(RST_I), .RX_I(RX_I), .DIVISOR_I(DIVISOR_I),
        .WLS_I(WLS_I), .PEN_I(PEN_I), .EPS_I(EPS_I), .RD_I(RD_I),
        .LSR_RD_I(LSR_RD_I), .FIFO_CLR_I(FIFO_CLR_I), .DATA_O(DATA_O),
        .DR_O(DR_O), .OE_O(OE_O), .PE_O(PE_O), .FE_O(FE_O), .BI_O(BI_O),
        .COUNT_O(COUNT_O)
    );

    always #5 CLK_I = ~CLK_I;

    typedef struct {
        logic [15:0] div;
        logic [1:0]  wls;
        logic        pen;
        logic        eps;
        logic        flip;
        logic        stop;
        logic [7:0]  tx;
        logic [7:0]  exp_data;
        logic        exp_pe;
        logic        exp_fe;
        logic        exp_bi;
    } vec_t;

    vec_t vecs[9];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic step();
        @(posedge CLK_I);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called just after a clock edge; the first line drop happens immediately.
    task automatic send_char(input logic [7:0] d, input int nbits, input logic pen,
                             input logic pbit, input logic stop, input int bclk);
        RX_I = 1'b0;
        repeat (bclk) step();
        for (int i = 0; i < nbits; i++) begin
            RX_I = d[i];
            repeat (bclk) step();
        end
        if (pen) begin
            RX_I = pbit;
            repeat (bclk) step();
        end
        RX_I = stop;
        repeat (bclk) step();
        RX_I = 1'b1;
    endtask

    task automatic send_8n1(input logic [7:0] d);
        send_char(d, 8, 1'b0, 1'b0, 1'b1, 16);
        repeat (16) step();
    endtask

    task automatic pulse_rd();
        RD_I = 1'b1;
        step();
        RD_I = 1'b0;
    endtask

    task automatic wait_dr(input int budget);
        int w;
        w = 0;
        while (!DR_O && w < budget) begin
            step();
            w++;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_data"}, 32'(DATA_O), 32'h0);
        chk({tag, "_dr"}, 32'(DR_O), 32'h0);
        chk({tag, "_oe"}, 32'(OE_O), 32'h0);
        chk({tag, "_flags"}, {29'd0, BI_O, FE_O, PE_O}, 32'h0);
        chk({tag, "_count"}, 32'(COUNT_O), 32'h0);
    endtask

    initial begin
        //         div    wls  pen  eps  flip stop tx      data   pe   fe   bi
        vecs[0] = '{16'd1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 8'h55, 8'h55, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'd3, 2'd2, 1'b1, 1'b1, 1'b0, 1'b1, 8'h41, 8'h41, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{16'd3, 2'd2, 1'b1, 1'b1, 1'b1, 1'b1, 8'h41, 8'h41, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{16'd1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3A, 8'h1A, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{16'd2, 2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h2C, 8'h2C, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{16'd1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA7, 8'hA7, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{16'd1, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1};
        vecs[7] = '{16'd1, 2'd3, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1};
        vecs[8] = '{16'd0, 2'd3, 1'b1, 1'b0, 1'b0, 1'b1, 8'hC3, 8'hC3, 1'b0, 1'b0, 1'b0};

        repeat (3) step();
        RST_I = 1'b0;
        step();
        chk_all_zero("reset");

        // Exact latency: start detect 3 clocks after the fall, push visible 153 clocks later.
        DIVISOR_I = 16'd1; WLS_I = 2'd3; PEN_I = 1'b0; EPS_I = 1'b0;
        fork
            send_char(8'h55, 8, 1'b0, 1'b0, 1'b1, 16);
            begin
                repeat (155) step();
                chk("lat_dr_before", 32'(DR_O), 32'h0);
                step();
                chk("lat_dr_at", 32'(DR_O), 32'h1);
                chk("lat_data", 32'(DATA_O), 32'h55);
                chk("lat_flags", {29'd0, BI_O, FE_O, PE_O}, 32'h0);
            end
        join
        repeat (16) step();
        pulse_rd();
        chk("lat_pop_dr", 32'(DR_O), 32'h0);
        chk("lat_pop_data", 32'(DATA_O), 32'h0);

        for (int v = 0; v < 9; v++) begin
            int bclk;
            int nb;
            logic [7:0] masked;
            logic pbit;
            DIVISOR_I = vecs[v].div;
            WLS_I     = vecs[v].wls;
            PEN_I     = vecs[v].pen;
            EPS_I     = vecs[v].eps;
            bclk   = 16 * ((vecs[v].div == 16'd0) ? 1 : int'(vecs[v].div));
            nb     = int'(vecs[v].wls) + 5;
            masked = vecs[v].tx & ((8'd1 << nb) - 8'd1);
            pbit   = (vecs[v].eps ? ^masked : ~^masked) ^ vecs[v].flip;
            send_char(vecs[v].tx, nb, vecs[v].pen, pbit, vecs[v].stop, bclk);
            repeat (2 * bclk) step();
            wait_dr(2000);
            chk($sformatf("vec%0d_count", v), 32'(COUNT_O), 32'h1);
            chk($sformatf("vec%0d_data", v), 32'(DATA_O), 32'(vecs[v].exp_data));
            chk($sformatf("vec%0d_pe", v), 32'(PE_O), 32'(vecs[v].exp_pe));
            chk($sformatf("vec%0d_fe", v), 32'(FE_O), 32'(vecs[v].exp_fe));
            chk($sformatf("vec%0d_bi", v), 32'(BI_O), 32'(vecs[v].exp_bi));
            pulse_rd();
            chk($sformatf("vec%0d_pop", v), 32'(DR_O), 32'h0);
        end

        // Line held low for two character times: one break entry only.
        DIVISOR_I = 16'd1; WLS_I = 2'd3; PEN_I = 1'b0;
        RX_I = 1'b0;
        repeat (320) step();
        RX_I = 1'b1;
        repeat (200) step();
        chk("brk_count", 32'(COUNT_O), 32'h1);
        chk("brk_data", 32'(DATA_O), 32'h0);
        chk("brk_flags", {29'd0, BI_O, FE_O, PE_O}, 32'h6);
        pulse_rd();

        // Short low glitch is rejected at the mid-start check.
        RX_I = 1'b0;
        repeat (4) step();
        RX_I = 1'b1;
        repeat (200) step();
        chk("glitch_count", 32'(COUNT_O), 32'h0);

        // Overrun: 17 characters into 16 entries.
        for (int i = 0; i < 17; i++) send_8n1(8'h10 + 8'(i));
        chk("ovr_count", 32'(COUNT_O), 32'h10);
        chk("ovr_oe", 32'(OE_O), 32'h1);
        LSR_RD_I = 1'b1;
        step();
        LSR_RD_I = 1'b0;
        chk("ovr_oe_clr", 32'(OE_O), 32'h0);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("ovr_pop%0d", i), 32'(DATA_O), 32'(8'h10 + 8'(i)));
            pulse_rd();
        end
        chk("ovr_empty_dr", 32'(DR_O), 32'h0);
        chk("ovr_empty_count", 32'(COUNT_O), 32'h0);

        // Pop coincident with the 17th push: both succeed, no overrun.
        for (int i = 0; i < 16; i++) send_8n1(8'h20 + 8'(i));
        fork
            send_char(8'h30, 8, 1'b0, 1'b0, 1'b1, 16);
            begin
                repeat (155) step();
                RD_I = 1'b1;
                step();
                RD_I = 1'b0;
            end
        join
        repeat (16) step();
        chk("pp_oe", 32'(OE_O), 32'h0);
        chk("pp_count", 32'(COUNT_O), 32'h10);
        chk("pp_head", 32'(DATA_O), 32'h21);

        // Clear on the push cycle of a full FIFO: character lost, no overrun.
        fork
            send_char(8'h40, 8, 1'b0, 1'b0, 1'b1, 16);
            begin
                repeat (155) step();
                FIFO_CLR_I = 1'b1;
                step();
                FIFO_CLR_I = 1'b0;
            end
        join
        repeat (16) step();
        chk_all_zero("clr");

        // Reset mid-DATA with a flagged entry queued.
        send_char(8'hA7, 8, 1'b0, 1'b0, 1'b0, 16);
        repeat (32) step();
        chk("pre_rst_fe", 32'(FE_O), 32'h1);
        fork
            send_char(8'hFF, 8, 1'b0, 1'b0, 1'b1, 16);
            begin
                repeat (60) step();
                RST_I = 1'b1;
                step();
                RST_I = 1'b0;
            end
        join
        repeat (32) step();
        chk_all_zero("rst");
        send_8n1(8'h3C);
        wait_dr(500);
        chk("post_rst_count", 32'(COUNT_O), 32'h1);
        chk("post_rst_data", 32'(DATA_O), 32'h3C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
